// File: rtl/hbridge_dir_driver.sv
// hbridge_dir_driver: Wishbone-controlled H-bridge steering of pwm_in onto in1/in2
// with dead time on reversal and a latched driver fault.
// Ports:
//   wb_clk, wb_rst_n     clock, async active-low reset
//   pwm_in               PWM from dc_motor_controller (wb_clk domain)
//   fault_n              async driver nFAULT, synchronized internally
//   wb_*                 Wishbone slave (one wait state, registered read data)
//   in1, in2             registered bridge inputs
//   state_o              current FSM state
module hbridge_dir_driver #(
   parameter int unsigned DEAD_DEFAULT = 50
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        pwm_in,
   input  logic        fault_n,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack,
   output logic [31:0] wb_dat_o,
   output logic        in1,
   output logic        in2,
   output logic [2:0]  state_o
);
   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_FWD   = 3'd1,
      S_REV   = 3'd2,
      S_DEAD  = 3'd3,
      S_BRAKE = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t      r_state, w_nxt;
   logic        r_fault_s1, r_fault_s2, r_fault_latched, r_dir, r_ack, r_in1, r_in2;
   logic [2:0]  r_ctrl;
   logic [7:0]  r_dead, r_cnt;
   logic [31:0] r_dat_o, w_rd;
   logic [3:0]  w_idx;
   logic        w_req, w_wr, w_en, w_dirc, w_brake, w_load, w_unused;

   assign w_idx    = wb_adr[5:2];
   assign w_req    = wb_cyc & wb_stb & ~r_ack;
   assign w_wr     = w_req & wb_we;
   assign w_en     = r_ctrl[0];
   assign w_dirc   = r_ctrl[1];
   assign w_brake  = r_ctrl[2];
   assign w_unused = ^{wb_sel, wb_adr[31:6], wb_adr[1:0], wb_dat_i[31:8]};

   assign wb_ack   = r_ack;
   assign wb_dat_o = r_dat_o;
   assign in1      = r_in1;
   assign in2      = r_in2;
   assign state_o  = r_state;

   always_comb begin
      w_rd = (w_idx == 4'd0) ? {29'd0, r_ctrl} :
             (w_idx == 4'd1) ? {24'd0, r_dead} :
             (w_idx == 4'd2) ? {16'd0, r_cnt, 3'd0, r_dir, r_fault_latched, r_state} : 32'd0;
   end

   always_comb begin
      w_nxt  = r_state;
      w_load = 1'b0;
      if (!r_fault_s2)
         w_nxt = S_FAULT;
      else if (r_state == S_FAULT)
         w_nxt = r_fault_latched ? S_FAULT : S_OFF;
      else if (r_state == S_BRAKE)
         w_nxt = w_brake ? S_BRAKE : S_OFF;
      else if (w_brake)
         w_nxt = S_BRAKE;
      else if (!w_en)
         w_nxt = S_OFF;
      else begin
         case (r_state)
            S_OFF: w_nxt = w_dirc ? S_REV : S_FWD;
            S_FWD: if (w_dirc) begin
               w_nxt  = (r_dead == 8'd0) ? S_REV : S_DEAD;
               w_load = (r_dead != 8'd0);
            end
            S_REV: if (!w_dirc) begin
               w_nxt  = (r_dead == 8'd0) ? S_FWD : S_DEAD;
               w_load = (r_dead != 8'd0);
            end
            // exit direction follows the dir bit at the end of the dead time
            S_DEAD: if (r_cnt <= 8'd1) w_nxt = w_dirc ? S_REV : S_FWD;
            default: w_nxt = S_OFF;
         endcase
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n)
         r_state <= S_OFF;
      else
         r_state <= w_nxt;
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_fault_s1      <= 1'b1;
         r_fault_s2      <= 1'b1;
         r_fault_latched <= 1'b0;
         r_ack           <= 1'b0;
         r_dat_o         <= 32'd0;
         r_ctrl          <= 3'd0;
         r_dead          <= 8'(DEAD_DEFAULT);
         r_cnt           <= 8'd0;
         r_dir           <= 1'b0;
         r_in1           <= 1'b0;
         r_in2           <= 1'b0;
      end else begin
         r_fault_s1 <= fault_n;
         r_fault_s2 <= r_fault_s1;
         r_ack      <= w_req;
         if (w_req) r_dat_o <= w_rd;
         if (w_wr && w_idx == 4'd0) r_ctrl <= wb_dat_i[2:0];
         if (w_wr && w_idx == 4'd1) r_dead <= wb_dat_i[7:0];
         // clear only takes effect once the synchronized fault pin is back high
         if (!r_fault_s2)
            r_fault_latched <= 1'b1;
         else if (w_wr && w_idx == 4'd2 && wb_dat_i[3])
            r_fault_latched <= 1'b0;
         if (w_load)
            r_cnt <= r_dead;
         else if (r_state == S_DEAD)
            r_cnt <= r_cnt - 8'd1;
         if (w_nxt == S_FWD)
            r_dir <= 1'b0;
         else if (w_nxt == S_REV)
            r_dir <= 1'b1;
         r_in1 <= (r_state == S_BRAKE) | ((r_state == S_FWD) & pwm_in);
         r_in2 <= (r_state == S_BRAKE) | ((r_state == S_REV) & pwm_in);
      end
   end
endmodule

// File: tb/tb_hbridge_dir_driver.sv
// tb_hbridge_dir_driver: directed vectors for hbridge_dir_driver
module tb_hbridge_dir_driver;
   logic        wb_clk = 1'b0, wb_rst_n = 1'b0, pwm_in = 1'b0, fault_n = 1'b1;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'hf;
   logic [31:0] wb_adr = 32'd0, wb_dat_i = 32'd0;
   logic        wb_ack, in1, in2;
   logic [31:0] wb_dat_o;
   logic [2:0]  state_o;

   int          n_vec = 0, n_err = 0, pcnt = 0;
   logic        pwm_prev = 1'b0;
   logic [31:0] rd;
   logic [5:0]  ack_seq;
   int          n_dead, nz;

   hbridge_dir_driver #(.DEAD_DEFAULT(50)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .pwm_in(pwm_in), .fault_n(fault_n),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_dat_o(wb_dat_o),
      .in1(in1), .in2(in2), .state_o(state_o)
   );

   always #5 wb_clk = ~wb_clk;

   // advance to the next falling edge; pwm_prev is the pwm value seen at the rising edge just passed
   task automatic step();
      @(negedge wb_clk);
      pwm_prev = pwm_in;
      pwm_in   = (pcnt % 4 == 0);
      pcnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] idx, input logic [31:0] wd,
                          output logic [31:0] rdat);
      bit got;
      got      = 1'b0;
      rdat     = 32'd0;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_adr   = {26'd0, idx, 2'b00};
      wb_dat_i = wd;
      for (int i = 0; i < 4 && !got; i++) begin
         step();
         if (wb_ack) begin
            got  = 1'b1;
            rdat = wb_dat_o;
         end
      end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wb_wr(input logic [3:0] idx, input logic [31:0] wd);
      logic [31:0] dummy;
      wb_xfer(1'b1, idx, wd, dummy);
   endtask

   task automatic wb_rd(input logic [3:0] idx, output logic [31:0] rdat);
      wb_xfer(1'b0, idx, 32'd0, rdat);
   endtask

   // count further DEAD cycles until the state leaves DEAD, noting any nonzero output
   task automatic run_dead();
      for (int i = 0; i < 40; i++) begin
         step();
         if (in1 | in2) nz++;
         if (state_o == 3'd3) n_dead++;
         else return;
      end
      chk("dead_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      step();
      step();
      chk("rst_state", state_o, 0);
      chk("rst_in1", in1, 0);
      chk("rst_in2", in2, 0);
      chk("rst_ack", wb_ack, 0);
      chk("rst_dat", wb_dat_o, 0);
      wb_rst_n = 1'b1;
      step();
      wb_rd(4'd0, rd); chk("ctrl_rst", rd, 0);
      wb_rd(4'd1, rd); chk("dead_rst", rd, 50);
      wb_rd(4'd2, rd); chk("status_rst", rd, 0);

      // enable forward
      wb_wr(4'd0, 32'd1);
      step();
      chk("fwd_state", state_o, 1);
      chk("fwd_out_lag", in1, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("fwd_in1", in1, pwm_prev);
         chk("fwd_in2", in2, 0);
      end

      // reversal with dead time 10
      wb_wr(4'd1, 32'd10);
      wb_wr(4'd0, 32'd3);
      step();
      chk("rev_dead_entry", state_o, 3);
      n_dead = 1; nz = 0;
      run_dead();
      chk("rev_dead_cycles", n_dead, 10);
      chk("rev_dead_zero", nz, 0);
      chk("rev_state", state_o, 2);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rev_in2", in2, pwm_prev);
         chk("rev_in1", in1, 0);
      end
      wb_rd(4'd2, rd); chk("rev_status", rd, 32'h12);

      // zero dead time: REV -> FWD with no DEAD cycle
      wb_wr(4'd1, 32'd0);
      wb_wr(4'd0, 32'd1);
      step();
      chk("zero_dead_state", state_o, 1);
      step();
      chk("zero_dead_in1", in1, pwm_prev);
      chk("zero_dead_in2", in2, 0);

      // dir bounce during an 8-cycle dead time
      wb_wr(4'd1, 32'd8);
      wb_wr(4'd0, 32'd3);
      step();
      chk("bounce_entry", state_o, 3);
      wb_wr(4'd0, 32'd1);
      chk("bounce_mid", state_o, 3);
      n_dead = 2; nz = 0;
      run_dead();
      chk("bounce_cycles", n_dead, 8);
      chk("bounce_resume", state_o, 1);

      // brake priority from REV
      wb_wr(4'd1, 32'd0);
      wb_wr(4'd0, 32'd3);
      step();
      chk("pre_brake_rev", state_o, 2);
      wb_wr(4'd0, 32'd7);
      step();
      chk("brake_state", state_o, 4);
      step();
      chk("brake_in1", in1, 1);
      chk("brake_in2", in2, 1);
      wb_wr(4'd0, 32'd1);
      step();
      chk("unbrake_off", state_o, 0);
      step();
      chk("unbrake_fwd", state_o, 1);

      // fault
      fault_n = 1'b0;
      repeat (5) step();
      chk("fault_state", state_o, 5);
      chk("fault_in1", in1, 0);
      chk("fault_in2", in2, 0);
      wb_rd(4'd2, rd); chk("fault_status", rd, 32'h0d);
      wb_wr(4'd2, 32'h8);
      wb_rd(4'd2, rd); chk("fault_clr_blocked", rd, 32'h0d);
      fault_n = 1'b1;
      repeat (3) step();
      chk("fault_held", state_o, 5);
      wb_wr(4'd2, 32'h8);
      step();
      chk("fault_clr_off", state_o, 0);
      step();
      chk("fault_resume", state_o, 1);
      wb_rd(4'd2, rd); chk("fault_clr_status", rd, 32'h01);

      // bus: unmapped read and back-to-back strobes
      wb_rd(4'd5, rd); chk("rd_idx5", rd, 0);
      step();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd0;
      for (int i = 5; i >= 0; i--) begin
         step();
         ack_seq[i] = wb_ack;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0;
      chk("ack_pulses", ack_seq, 6'b101010);

      // reset in the middle of a dead time
      wb_wr(4'd1, 32'd20);
      wb_wr(4'd0, 32'd3);
      repeat (3) step();
      chk("mid_dead_state", state_o, 3);
      wb_rst_n = 1'b0;
      #1;
      chk("async_rst_state", state_o, 0);
      chk("async_rst_in1", in1, 0);
      chk("async_rst_in2", in2, 0);
      step();
      wb_rst_n = 1'b1;
      step();
      chk("post_rst_state", state_o, 0);
      wb_rd(4'd1, rd); chk("post_rst_dead", rd, 50);
      wb_rd(4'd0, rd); chk("post_rst_ctrl", rd, 0);
      wb_rd(4'd2, rd); chk("post_rst_status", rd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
